imem_fetch_port: RTL

Instruction-memory responder on the fetch side of the core: consumes the 32-bit byte address that the program counter issues every cycle and returns the addressed 32-bit instruction word through a fixed-latency pipeline. It tags each returned word with its fetch address and a fault code. It supports fetch stall, branch flush of in-flight fetches, and a preload write port used by the bench or boot logic to fill the instruction store.

---
 rtl/imem_fetch_port.sv | 83 ++++++++
 1 files changed

// File: rtl/imem_fetch_port.sv
// Fixed-latency instruction-memory responder: each accepted fetch returns its word,
// tagged with the fetch address and a fault code, LATENCY cycles later.
module imem_fetch_port #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   ins_address,
    input  logic          req_valid,
    input  logic          stall,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   instruction,
    output logic          ins_valid,
    output logic [31:0]   ins_pc,
    output logic [1:0]    fault
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [1:0]  fault;
        logic [31:0] data;
    } stage_t;

    logic [31:0] mem [DEPTH];
    stage_t      pipe [LATENCY];
    stage_t      new_stage;
    logic [AW-1:0] req_idx;
    logic [1:0]  req_fault;
    logic        accept;

    // Handshake: req_valid is taken when the pipe can move (no stall) or a flush
    // redirects it; there is no ready output, so a stalled requester re-presents.
    always_comb begin
        new_stage = '0;
        req_idx   = ins_address[AW+1:2];
        req_fault = {|ins_address[31:AW+2], |ins_address[1:0]};
        accept    = req_valid && (!stall || flush);
        if (accept) begin
            new_stage.valid = 1'b1;
            new_stage.pc    = ins_address;
            new_stage.fault = req_fault;
            new_stage.data  = (req_fault == 2'b00) ? mem[req_idx] : 32'h0000_0000;
        end
    end

    // Preload port; a same-edge read above still sees the old word.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else if (flush) begin
            // Branch taken: only the concurrent request (the target) survives.
            pipe[0] <= new_stage;
            for (int i = 1; i < LATENCY; i++) begin
                pipe[i].valid <= 1'b0;
            end
        end else if (!stall) begin
            pipe[0] <= new_stage;
            for (int i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign ins_valid   = pipe[LATENCY-1].valid;
    assign ins_pc      = pipe[LATENCY-1].pc;
    assign fault       = pipe[LATENCY-1].fault;
    assign instruction = pipe[LATENCY-1].data;

endmodule
